// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared types for the sequential odd-even transposition sorter
package sorter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_swap.sv
// rtl/cmp_swap.sv - compare-exchange cell; lo drives the lower lane, hi the upper lane
module cmp_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  // Strict compare: equal elements stay in place.
  assign swapped = desc ? (a < b) : (a > b);
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;

endmodule

// File: rtl/seq_sorter.sv
// rtl/seq_sorter.sv - odd-even transposition sorter, one phase per clock, early exit when sorted
module seq_sorter
  import sorter_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_desc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data
);

  localparam int PW = $clog2(N + 1);

  state_t                 state;
  logic [N*W-1:0]         work;
  logic [N*W-1:0]         phased;
  logic                   desc_q;
  logic [PW-1:0]          phase;
  logic                   prev_swap;
  logic                   any_swap;
  logic                   done_now;
  logic                   accept;
  logic [N-2:0]           cell_en;
  logic [N-2:0]           cell_swap;
  logic [N-2:0][W-1:0]    cell_lo;
  logic [N-2:0][W-1:0]    cell_hi;

  for (genvar j = 0; j < N - 1; j++) begin : g_cell
    cmp_swap #(.W(W)) u_cmp_swap (
      .a       (work[j*W +: W]),
      .b       (work[(j+1)*W +: W]),
      .desc    (desc_q),
      .lo      (cell_lo[j]),
      .hi      (cell_hi[j]),
      .swapped (cell_swap[j])
    );
  end

  // Enabled cells never share a lane, so their writes cannot collide.
  always_comb begin
    phased  = work;
    cell_en = '0;
    for (int j = 0; j < N - 1; j++) begin
      cell_en[j] = (j % 2 == 1) ? phase[0] : ~phase[0];
      if (cell_en[j]) begin
        phased[j*W +: W]     = cell_lo[j];
        phased[(j+1)*W +: W] = cell_hi[j];
      end
    end
  end

  assign any_swap = |(cell_swap & cell_en);
  assign done_now = (phase == PW'(N - 1)) ||
                    ((phase != '0) && !any_swap && !prev_swap);

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign out_data = work;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      work      <= '0;
      desc_q    <= 1'b0;
      phase     <= '0;
      prev_swap <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= SORT;
        end
        SORT: begin
          work      <= phased;
          prev_swap <= any_swap;
          if (done_now) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? SORT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Input handshake only occurs in IDLE or DONE, never alongside SORT updates.
      if (accept) begin
        work      <= in_data;
        desc_q    <= in_desc;
        phase     <= '0;
        prev_swap <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_sorter.sv
// tb/tb_seq_sorter.sv - directed table plus corner sequences at N=4, random regression at N=7 W=8
module tb_seq_sorter;

  logic        clk = 1'b0;
  logic        nrst;

  logic        in_valid, in_ready, in_desc, out_valid, out_ready;
  logic [15:0] in_data, out_data;

  logic        r_in_valid, r_in_ready, r_in_desc, r_out_valid, r_out_ready;
  logic [55:0] r_in_data, r_out_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_sorter u_dut4 (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_desc   (in_desc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  seq_sorter #(.W(8), .N(7)) u_dut7 (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (r_in_valid),
    .in_ready  (r_in_ready),
    .in_data   (r_in_data),
    .in_desc   (r_in_desc),
    .out_valid (r_out_valid),
    .out_ready (r_out_ready),
    .out_data  (r_out_data)
  );

  typedef struct {
    logic [15:0] data;
    logic        desc;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] ref_sort(input logic [55:0] d, input logic desc);
    logic [7:0] a [7];
    logic [7:0] t;
    logic [55:0] r;
    for (int i = 0; i < 7; i++) a[i] = d[i*8 +: 8];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 6 - i; j++)
        if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < 7; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  // Present one vector, count edges until out_valid, check result and latency, then drain.
  task automatic run_vec(input string name, input logic [15:0] d, input logic desc,
                         input logic [15:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({name, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; in_data = d; in_desc = desc; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_data = 16'hDEAD; in_desc = ~desc;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_data"}, out_data, exp);
    chk({name, "_lat"}, lat, exp_lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_drain"}, out_valid, 1'b0);
  endtask

  initial begin
    vec_t vt [7];
    int   lat;
    int   tries;
    logic [55:0] exp7, held;

    vt[0] = '{16'h1234, 1'b0, 16'h4321, 4};
    vt[1] = '{16'h4321, 1'b0, 16'h4321, 2};
    vt[2] = '{16'h4321, 1'b1, 16'h1234, 4};
    vt[3] = '{16'h2121, 1'b0, 16'h2211, 4};
    vt[4] = '{16'h7777, 1'b0, 16'h7777, 2};
    vt[5] = '{16'h7777, 1'b1, 16'h7777, 2};
    vt[6] = '{16'h1234, 1'b1, 16'h1234, 2};

    nrst = 1'b0;
    in_valid = 1'b0; in_data = '0; in_desc = 1'b0; out_ready = 1'b0;
    r_in_valid = 1'b0; r_in_data = '0; r_in_desc = 1'b0; r_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    nrst = 1'b1;

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vt[i].data, vt[i].desc, vt[i].exp, vt[i].lat);

    // Backpressure then simultaneous output and input handshake.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h1234; in_desc = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 16'h4321);
      chk("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0F00; in_desc = 1'b0;
    #1;
    chk("b2b_in_ready", in_ready, 1'b1);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; in_data = 16'hFFFF;
    chk("b2b_sorting", out_valid, 1'b0);
    chk("b2b_busy", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b_data", out_data, 16'hF000);
    chk("b2b_lat", lat, 3);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset while phase 1 is in progress.
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h1234; in_desc = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 16'h0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    nrst = 1'b1;
    run_vec("post_rst", 16'h3142, 1'b0, 16'h4321, 4);

    // Random regression on the N=7, W=8 instance.
    for (int v = 0; v < 1000; v++) begin
      @(negedge clk);
      r_in_valid = 1'b1;
      r_in_data  = {$urandom, $urandom};
      r_in_desc  = 1'($urandom_range(0, 1));
      exp7       = ref_sort(r_in_data, r_in_desc);
      chk("rnd_in_ready", r_in_ready, 1'b1);
      @(negedge clk);
      r_in_valid = 1'b0;
      r_in_data  = {$urandom, $urandom};
      lat = 0;
      while (!r_out_valid && lat < 12) begin
        r_out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        lat++;
      end
      chk("rnd_lat_le7", (lat >= 2 && lat <= 7), 1'b1);
      chk("rnd_data", r_out_data, exp7);
      held  = r_out_data;
      tries = 0;
      r_out_ready = 1'($urandom_range(0, 1));
      while (!r_out_ready) begin
        @(negedge clk);
        chk("rnd_hold_valid", r_out_valid, 1'b1);
        chk("rnd_hold_data", r_out_data, held);
        tries++;
        r_out_ready = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      r_out_ready = 1'b0;
      chk("rnd_drain", r_out_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_sorter.md
# seq_sorter

Parametrised sequential sorter for N unsigned W-bit elements packed into one vector, with selectable ascending/descending order. Uses odd-even transposition: one compare-exchange phase per clock, with valid/ready handshakes on input and output. Early termination once the vector is sorted. Sits between a producer and consumer of packed element vectors, replacing the fixed 4×4-bit combinational network where wider or deeper vectors are needed.

## Interface
Parameters:
- W, 4, element width in bits (≥1)
- N, 4, element count (≥2)

Ports (clock is `clk`; reset is `nrst`, asynchronous and active-low):
- clk  input  1  clock, rising-edge
- nrst  input  1  asynchronous active-low reset
- in_valid  input  1  producer offers in_data/in_desc
- in_ready  output  1  block can accept a vector
- in_data  input  N*W  lane k = in_data[k*W +: W]
- in_desc  input  1  0: ascending (lane N-1 largest); 1: descending (lane 0 largest)
- out_valid  output  1  out_data holds a sorted vector
- out_ready  input  1  consumer accepts out_data
- out_data  output  N*W  sorted vector, same lane packing

## Operation
- States: IDLE, SORT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch in_data into the working register, latch in_desc, clear phase counter and swap history, go to SORT.
- SORT: in_ready=0, out_valid=0. Each cycle applies phase p:
  - p even: pairs (0,1),(2,3),…
  - p odd: pairs (1,2),(3,4),…
  - Unpaired edge lanes pass through.
- Compare-exchange on pair (j,j+1): ascending swaps iff lane j > lane j+1. Descending swaps iff lane j < lane j+1. Unsigned, strict compare, so equal elements are never swapped.
- Phase counter is $clog2(N+1) bits and increments each SORT cycle.
- SORT→DONE after the phase with p = N-1 completes.
- Early exit: SORT→DONE also after a phase p≥1 that performs no swap when phase p-1 also performed no swap.
- DONE: out_valid=1, out_data = working register, held stable while out_ready=0. in_ready = out_ready.
  - out_ready && !in_valid: go to IDLE.
  - out_ready && in_valid: accept the new vector in the same cycle and go to SORT (back-to-back).
- in_data and in_desc are sampled only at the input handshake. Later changes have no effect.
- Reset (any state, including mid-SORT):
  - state IDLE, working register 0, phase counter 0, swap history cleared
  - out_valid=0, out_data=0, in_ready=1
  - any in-flight vector is discarded

## Timing
- Input accepted at edge k.
- Phases execute on edges k+1 … k+m, with m = N worst case and m = 2 minimum (already sorted input).
- out_valid rises after edge k+m.
- Output handshake at edge d returns the block to IDLE, or to SORT on a simultaneous input handshake. No idle bubble on back-to-back transfers.
- out_valid and out_data are registered. in_ready is combinational from state and out_ready only; it has no path from in_valid.
- Throughput: one vector per (m+1) cycles with back-to-back handshakes.

## Structure
- Package `sorter_pkg`: state enum typedef (IDLE/SORT/DONE).
- Sub-module `cmp_swap` (combinational):
  - parameter W
  - inputs a, b, desc
  - outputs lo, hi, swapped
- The top instantiates N-1 `cmp_swap` cells, one per adjacent pair. Per-phase enables select even or odd cells. The swap flags are OR-reduced for the early-exit logic.

## Test plan
Default N=4, W=4. Vectors are written as 16'h{lane3 lane2 lane1 lane0}.
- Reverse input: in_data=16'h1234, asc → out_data=16'h4321, out_valid exactly 4 cycles after accept, swaps in every phase.
- Sorted input: in_data=16'h4321, asc → out_data=16'h4321 after 2 SORT cycles (early exit). Same data with desc=1 → 16'h1234 after 4 cycles.
- Duplicates: in_data=16'h2121, asc → 16'h2211. 16'h7777 → 16'h7777 after 2 cycles.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles → out_valid=1, out_data constant, in_ready=0.
  - Then raise out_ready with in_valid=1 and in_data=16'h0F00 → both handshakes on the same edge, next output 16'hF000.
- Reset mid-SORT: drop nrst during phase 1 → out_valid=0, out_data=0, in_ready=1 immediately. A fresh vector after release sorts correctly.
- Random regression at N=7, W=8 (odd N): 1000 random vectors, random desc, random out_ready. Compare against a reference model, check latency ≤7 cycles, check stability under backpressure.
